// File: rtl/matrix_scanner.sv
// Row-multiplexed LED dot-matrix scanner with a 1-bit framebuffer and shift-register drive.
// Optional macro SCREEN_ROWFIX_EN swaps adjacent row pairs for the v01 board wiring.
module matrix_scanner #(
  parameter int unsigned ROWS = 16,
  parameter int unsigned COLS = 16,
  parameter int unsigned HOLD = 2048
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [$clog2(COLS)-1:0] wr_x,
  input  logic [$clog2(ROWS)-1:0] wr_y,
  input  logic                    wr_data,
  input  logic                    clear,
  output logic                    rsdi,
  output logic                    rclk,
  output logic                    csdi,
  output logic                    cclk,
  output logic                    le,
  output logic                    oeb,
  output logic                    frame_start
);

  localparam int unsigned XW    = $clog2(COLS);
  localparam int unsigned YW    = $clog2(ROWS);
  localparam int unsigned HoldW = (HOLD > 1) ? $clog2(HOLD) : 1;

  localparam logic [XW-1:0]    SlotLast = XW'(COLS - 1);
  localparam logic [YW-1:0]    RowLast  = YW'(ROWS - 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD - 1);

  typedef enum logic [1:0] {StShift, StLatch, StHold} state_e;

  state_e                     state_q, state_d;
  logic [YW-1:0]              row_q, row_d;
  logic [XW-1:0]              slot_q, slot_d;
  logic                       phase_q, phase_d;
  logic [HoldW-1:0]           hold_q, hold_d;
  logic [ROWS-1:0][COLS-1:0]  fb_q, fb_d;

  logic rsdi_q, rsdi_d, rclk_q, rclk_d, csdi_q, csdi_d, cclk_q, cclk_d;
  logic le_q, le_d, oeb_q, oeb_d, fs_q, fs_d;

  logic [YW-1:0] row_p;
  logic [XW-1:0] col_idx;
  logic          x_ok, y_ok;

`ifdef SCREEN_ROWFIX_EN
  assign row_p = row_q ^ YW'(1);
`else
  assign row_p = row_q;
`endif

  // Columns shift out MSB first so the last bit shifted lands in column 0.
  assign col_idx = SlotLast - slot_q;
  assign x_ok    = (32'(wr_x) < COLS);
  assign y_ok    = (32'(wr_y) < ROWS);

  always_comb begin
    fb_d = fb_q;
    if (clear) begin
      fb_d = '0;
    end else if (wr_en && x_ok && y_ok) begin
      fb_d[wr_y][wr_x] = wr_data;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    slot_d  = slot_q;
    phase_d = phase_q;
    hold_d  = hold_q;
    rsdi_d  = 1'b1;
    rclk_d  = 1'b0;
    csdi_d  = 1'b0;
    cclk_d  = 1'b0;
    le_d    = 1'b0;
    oeb_d   = 1'b0;
    fs_d    = 1'b0;
    case (state_q)
      StShift: begin
        cclk_d  = phase_q;
        // Phase B holds the bit sampled in phase A so a late write cannot glitch it.
        csdi_d  = phase_q ? csdi_q : fb_q[row_p][col_idx];
        fs_d    = (row_q == '0) && (slot_q == '0) && !phase_q;
        phase_d = ~phase_q;
        if (phase_q) begin
          if (slot_q == SlotLast) begin
            slot_d  = '0;
            state_d = StLatch;
          end else begin
            slot_d = slot_q + 1'b1;
          end
        end
      end
      StLatch: begin
        oeb_d   = 1'b1;
        phase_d = ~phase_q;
        if (!phase_q) begin
          rsdi_d = (row_q != '0);
        end else begin
          rclk_d  = 1'b1;
          le_d    = 1'b1;
          hold_d  = '0;
          state_d = StHold;
        end
      end
      StHold: begin
        if (hold_q == HoldLast) begin
          state_d = StShift;
          row_d   = (row_q == RowLast) ? '0 : row_q + 1'b1;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = StShift;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StShift;
      row_q   <= '0;
      slot_q  <= '0;
      phase_q <= 1'b0;
      hold_q  <= '0;
      fb_q    <= '0;
      rsdi_q  <= 1'b1;
      rclk_q  <= 1'b0;
      csdi_q  <= 1'b0;
      cclk_q  <= 1'b0;
      le_q    <= 1'b0;
      oeb_q   <= 1'b1;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      slot_q  <= slot_d;
      phase_q <= phase_d;
      hold_q  <= hold_d;
      fb_q    <= fb_d;
      rsdi_q  <= rsdi_d;
      rclk_q  <= rclk_d;
      csdi_q  <= csdi_d;
      cclk_q  <= cclk_d;
      le_q    <= le_d;
      oeb_q   <= oeb_d;
      fs_q    <= fs_d;
    end
  end

  assign rsdi        = rsdi_q;
  assign rclk        = rclk_q;
  assign csdi        = csdi_q;
  assign cclk        = cclk_q;
  assign le          = le_q;
  assign oeb         = oeb_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_matrix_scanner.sv
// Scoreboard bench for matrix_scanner (ROWS=4, COLS=4, HOLD=4): expected outputs come from
// a frame-timing model based on cycle arithmetic; a negedge monitor pops and compares.
module tb_matrix_scanner;

  localparam int R  = 4;
  localparam int C  = 4;
  localparam int H  = 4;
  localparam int RP = 2 * C + 2 + H;
  localparam int FP = R * RP;
  // Bit order: {rsdi, rclk, csdi, cclk, le, oeb, frame_start}
  localparam logic [6:0] RstV = 7'b1000010;

  logic       clk = 1'b0;
  logic       reset, wr_en, clear, wr_data;
  logic [1:0] wr_x, wr_y;
  logic       rsdi, rclk, csdi, cclk, le, oeb, frame_start;

  typedef struct packed {
    logic       rst;
    logic [6:0] v;
  } exp_t;

  exp_t q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   frame_checks = 0;
  bit   fb_m [R][C];
  int   t = 0;
  bit   last_c = 1'b0;

  matrix_scanner #(
    .ROWS(R),
    .COLS(C),
    .HOLD(H)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_x       (wr_x),
    .wr_y       (wr_y),
    .wr_data    (wr_data),
    .clear      (clear),
    .rsdi       (rsdi),
    .rclk       (rclk),
    .csdi       (csdi),
    .cclk       (cclk),
    .le         (le),
    .oeb        (oeb),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Predict what the DUT shows after the coming edge, then drive inputs for that edge.
  task automatic step(input bit rst, input bit clr, input bit we, input int x, input int y,
                      input bit d);
    exp_t       e;
    int         r, o, p;
    logic [6:0] v;
    if (rst) begin
      v = RstV;
    end else begin
      r = (t / RP) % R;
      o = t % RP;
`ifdef SCREEN_ROWFIX_EN
      p = r ^ 1;
`else
      p = r;
`endif
      v = 7'b1000000;
      if (o < 2 * C) begin
        if (o % 2 == 0) begin
          last_c = fb_m[p][C - 1 - o / 2];
          v[0]   = (r == 0 && o == 0);
        end else begin
          v[3] = 1'b1;
        end
        v[4] = last_c;
      end else if (o == 2 * C) begin
        v[1] = 1'b1;
        v[6] = (r != 0);
      end else if (o == 2 * C + 1) begin
        v[1] = 1'b1;
        v[5] = 1'b1;
        v[2] = 1'b1;
      end
    end
    e.rst = rst;
    e.v   = v;
    q.push_back(e);
    reset   = rst;
    clear   = clr;
    wr_en   = we;
    wr_x    = 2'(x);
    wr_y    = 2'(y);
    wr_data = d;
    @(posedge clk);
    #1;
    if (rst) begin
      t = 0;
      for (int i = 0; i < R; i++) for (int j = 0; j < C; j++) fb_m[i][j] = 1'b0;
    end else begin
      t++;
      if (clr) begin
        for (int i = 0; i < R; i++) for (int j = 0; j < C; j++) fb_m[i][j] = 1'b0;
      end else if (we) begin
        fb_m[y][x] = d;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  // Monitor: per-cycle scoreboard plus whole-frame event counting.
  exp_t       m_e;
  logic [6:0] got;
  logic       prev_cclk = 1'b0, prev_rclk = 1'b0;
  bit         fr_valid = 1'b0;
  int         fr_cyc = 0, cr = 0, rr = 0, lc = 0, oc = 0;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      m_e = q.pop_front();
      got = {rsdi, rclk, csdi, cclk, le, oeb, frame_start};
      vectors++;
      if (got !== m_e.v) begin
        miscompares++;
        $display("FAIL outputs t=%0d time=%0t got %b want %b (rsdi,rclk,csdi,cclk,le,oeb,fs)",
                 t, $time, got, m_e.v);
      end
      if (m_e.rst) begin
        fr_valid  = 1'b0;
        prev_cclk = 1'b0;
        prev_rclk = 1'b0;
      end else begin
        if (frame_start === 1'b1) begin
          if (fr_valid) begin
            vectors++;
            frame_checks++;
            if (cr != 4 * C || rr != R || lc != R || oc != 2 * R || fr_cyc != FP) begin
              miscompares++;
              $display("FAIL frame_counts got cclk=%0d rclk=%0d le=%0d oeb=%0d len=%0d want %0d %0d %0d %0d %0d",
                       cr, rr, lc, oc, fr_cyc, 4 * C, R, R, 2 * R, FP);
            end
          end
          fr_valid = 1'b1;
          fr_cyc = 0; cr = 0; rr = 0; lc = 0; oc = 0;
        end
        fr_cyc++;
        if (cclk === 1'b1 && prev_cclk === 1'b0) cr++;
        if (rclk === 1'b1 && prev_rclk === 1'b0) rr++;
        if (le === 1'b1) lc++;
        if (oeb === 1'b1) oc++;
        prev_cclk = cclk;
        prev_rclk = rclk;
      end
    end
  end

  initial begin
    bit rst_r, clr_r, we_r;
    int rv;
    step(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    // Two pixels in row 1 at the outer columns
    step(1'b0, 1'b0, 1'b1, 0, 1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 3, 1, 1'b1);
    idle(2 * FP + 2);
    // Reset while row 2, slot 1, phase B is on the outputs
    step(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1, 2, 1'b1);
    while (t != 32) idle(1);
    step(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    idle(FP + 4);
    // Clear wins over a simultaneous write
    step(1'b0, 1'b0, 1'b1, 2, 2, 1'b1);
    step(1'b0, 1'b1, 1'b1, 2, 2, 1'b1);
    idle(FP + 4);
    for (int i = 0; i < 700; i++) begin
      rv    = $urandom_range(0, 199);
      rst_r = (rv < 1);
      clr_r = (rv >= 1 && rv < 6);
      we_r  = ($urandom_range(0, 2) == 0);
      step(rst_r, clr_r, we_r, $urandom_range(0, C - 1), $urandom_range(0, R - 1),
           1'($urandom_range(0, 1)));
    end
    idle(FP + 2);
    @(negedge clk);
    #1;
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain got %0d pending want 0", q.size());
    end
    vectors++;
    if (frame_checks < 1) begin
      miscompares++;
      $display("FAIL frame_seen got %0d complete frames want >=1", frame_checks);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
